coeff_bank: RTL and testbench

Runtime-loadable, double-buffered coefficient store for the FIR datapath. Holds an active bank, which the MAC reads one coefficient per cycle by tap index, and a shadow bank, which a streaming load interface fills. The shadow becomes active only at a filter sample boundary, so a sample never uses a mix of old and new coefficients. An optional symmetric mode stores only half the taps and mirrors the read index.

---
 rtl/coeff_bank.sv | 151 +++++++++++++++
 tb/tb_coeff_bank.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_bank.sv
// rtl/coeff_bank.sv - double-buffered FIR coefficient store with streaming shadow load and sample-boundary swap
module coeff_bank #(
    parameter  int NUMBER_OF_TAPS = 64,
    parameter  int COEFF_BITS     = 16,
    parameter  int SYMMETRIC      = 0,
    localparam int COUNTER_BITS   = $clog2(NUMBER_OF_TAPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic signed [COEFF_BITS-1:0] load_data,
    input  logic                         load_last,
    input  logic                         swap_allow,
    input  logic [COUNTER_BITS-1:0]      current_count,
    output logic signed [COEFF_BITS-1:0] coeff,
    output logic                         bank_sel,
    output logic                         swap_pending,
    output logic                         load_error
);

    localparam int STORED   = (SYMMETRIC != 0) ? (NUMBER_OF_TAPS + 1) / 2 : NUMBER_OF_TAPS;
    localparam int PTR_BITS = (STORED > 1) ? $clog2(STORED) : 1;
    localparam int IDX_BITS = COUNTER_BITS + 1;

    localparam logic [PTR_BITS-1:0] LAST_PTR   = PTR_BITS'(STORED - 1);
    localparam logic [IDX_BITS-1:0] TAPS_EXT   = IDX_BITS'(NUMBER_OF_TAPS);
    localparam logic [IDX_BITS-1:0] STORED_EXT = IDX_BITS'(STORED);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOADING,
        ST_PENDING
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PTR_BITS-1:0]    wr_ptr;
    logic [PTR_BITS-1:0]    wr_ptr_next;
    logic                   frame_err;
    logic                   do_swap;
    logic                   accept;

    logic signed [COEFF_BITS-1:0] bank0 [STORED];
    logic signed [COEFF_BITS-1:0] bank1 [STORED];

    logic [IDX_BITS-1:0]          count_ext;
    logic [IDX_BITS-1:0]          rd_idx;
    logic                         in_range;
    logic signed [COEFF_BITS-1:0] rd_data;

    always_comb begin
        load_ready   = (state != ST_PENDING) && !rst;
        accept       = load_valid && load_ready;
        swap_pending = (state == ST_PENDING);
    end

    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        frame_err   = 1'b0;
        do_swap     = 1'b0;
        case (state)
            ST_IDLE, ST_LOADING: begin
                if (accept) begin
                    // load_last must coincide exactly with the final shadow slot
                    if (load_last != (wr_ptr == LAST_PTR)) begin
                        frame_err   = 1'b1;
                        state_next  = ST_IDLE;
                        wr_ptr_next = '0;
                    end else if (load_last) begin
                        state_next = ST_PENDING;
                    end else begin
                        state_next  = ST_LOADING;
                        wr_ptr_next = wr_ptr + PTR_BITS'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (swap_allow) begin
                    do_swap     = 1'b1;
                    state_next  = ST_IDLE;
                    wr_ptr_next = '0;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                wr_ptr_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            bank_sel   <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_ptr_next;
            bank_sel   <= bank_sel ^ do_swap;
            load_error <= frame_err;
        end
    end

    // The shadow is whichever bank bank_sel does not point at.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STORED; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STORED; i++) begin
                if (accept && (wr_ptr == PTR_BITS'(i))) begin
                    if (bank_sel) begin
                        bank0[i] <= load_data;
                    end else begin
                        bank1[i] <= load_data;
                    end
                end
            end
        end
    end

    always_comb begin
        count_ext = {1'b0, current_count};
        in_range  = (count_ext < TAPS_EXT);
        if ((SYMMETRIC != 0) && (count_ext >= STORED_EXT)) begin
            rd_idx = TAPS_EXT - IDX_BITS'(1) - count_ext;
        end else begin
            rd_idx = count_ext;
        end
        rd_data = '0;
        for (int i = 0; i < STORED; i++) begin
            if (in_range && (rd_idx == IDX_BITS'(i))) begin
                rd_data = bank_sel ? bank1[i] : bank0[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coeff <= '0;
        end else begin
            coeff <= rd_data;
        end
    end

endmodule

// File: tb/tb_coeff_bank.sv
// tb/tb_coeff_bank.sv - randomized self-checking bench for coeff_bank against a behavioural model
module tb_coeff_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic               lv, lr, ll, sa, sp, le, bs;
    logic signed [15:0] ld, cf;
    logic [5:0]         cnt;

    logic               s_lv, s_lr, s_ll, s_sa, s_sp, s_le, s_bs;
    logic signed [15:0] s_ld, s_cf;
    logic [2:0]         s_cnt;

    coeff_bank #(.NUMBER_OF_TAPS(64), .COEFF_BITS(16), .SYMMETRIC(0)) dut (
        .clk(clk), .rst(rst),
        .load_valid(lv), .load_ready(lr), .load_data(ld), .load_last(ll),
        .swap_allow(sa), .current_count(cnt), .coeff(cf),
        .bank_sel(bs), .swap_pending(sp), .load_error(le)
    );

    coeff_bank #(.NUMBER_OF_TAPS(7), .COEFF_BITS(16), .SYMMETRIC(1)) dut_sym (
        .clk(clk), .rst(rst),
        .load_valid(s_lv), .load_ready(s_lr), .load_data(s_ld), .load_last(s_ll),
        .swap_allow(s_sa), .current_count(s_cnt), .coeff(s_cf),
        .bank_sel(s_bs), .swap_pending(s_sp), .load_error(s_le)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int m_active [64];
    int m_load   [64];
    int m_bank;
    int m_sym    [4];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_sym(input int c);
        if (c >= 7) return 0;
        return m_sym[(c < 4) ? c : 6 - c];
    endfunction

    task automatic rd(input int c);
        cnt = 6'(c);
        tick();
        check($sformatf("coeff[%0d]", c), int'(cf), m_active[c]);
    endtask

    task automatic rd_rand(input int k);
        repeat (k) rd(int'($urandom_range(0, 63)));
    endtask

    task automatic rd_sym(input int c);
        s_cnt = 3'(c);
        tick();
        check($sformatf("sym_coeff[%0d]", c), int'(s_cf), exp_sym(c));
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) m_load[i] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    task automatic load_main(input int n, input int last_at, input bit swap_on_last);
        for (int i = 0; i < n; i++) begin
            lv = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
            lv = 1'b1;
            ld = 16'(m_load[i]);
            ll = (i == last_at);
            sa = swap_on_last && (i == n - 1);
            check("load_ready", int'(lr), 1);
            tick();
        end
        lv = 1'b0;
        ll = 1'b0;
        sa = 1'b0;
    endtask

    task automatic swap_main();
        int old5;
        cnt  = 6'd5;
        old5 = m_active[5];
        sa   = 1'b1;
        tick();
        sa = 1'b0;
        check("coeff_at_swap_edge", int'(cf), old5);
        m_bank   ^= 1;
        m_active = m_load;
        check("bank_sel_after_swap", int'(bs), m_bank);
        check("ready_after_swap", int'(lr), 1);
        check("pending_after_swap", int'(sp), 0);
    endtask

    initial begin
        rst = 1'b1;
        lv = 0; ll = 0; sa = 0; ld = '0; cnt = '0;
        s_lv = 0; s_ll = 0; s_sa = 0; s_ld = '0; s_cnt = '0;
        for (int i = 0; i < 64; i++) m_active[i] = 0;
        for (int i = 0; i < 4; i++) m_sym[i] = 0;
        m_bank = 0;

        tick();
        check("ready_in_rst", int'(lr), 0);
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_rst", int'(lr), 1);
        check("bank_sel_rst", int'(bs), 0);
        check("pending_rst", int'(sp), 0);
        check("error_rst", int'(le), 0);
        check("coeff_rst", int'(cf), 0);

        for (int c = 0; c < 64; c++) rd(c);
        for (int c = 0; c < 8; c++) rd_sym(c);

        // first load 1..64 held in shadow
        for (int i = 0; i < 64; i++) m_load[i] = i + 1;
        load_main(64, 63, 1'b0);
        check("pending_full", int'(sp), 1);
        check("ready_pending", int'(lr), 0);
        check("bank_sel_pre_swap", int'(bs), 0);
        rd_rand(8);

        swap_main();
        rd(5);
        rd_rand(16);

        // load_last on the third word
        fill_rand();
        load_main(3, 2, 1'b0);
        check("error_early_last", int'(le), 1);
        check("pending_after_err", int'(sp), 0);
        check("ready_after_err", int'(lr), 1);
        check("bank_sel_after_err", int'(bs), m_bank);
        tick();
        check("error_one_cycle", int'(le), 0);
        rd_rand(8);

        // 64th word without load_last
        load_main(64, -1, 1'b0);
        check("error_missing_last", int'(le), 1);
        tick();
        check("error_clear", int'(le), 0);

        fill_rand();
        load_main(64, 63, 1'b0);
        swap_main();
        rd_rand(16);

        sa = 1'b1;
        tick();
        sa = 1'b0;
        check("swap_ignored_idle", int'(bs), m_bank);
        check("pending_idle", int'(sp), 0);

        // final word coincides with swap_allow
        fill_rand();
        load_main(64, 63, 1'b1);
        check("no_swap_same_cycle", int'(bs), m_bank);
        check("pending_same_cycle", int'(sp), 1);
        lv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ld = 16'($urandom_range(0, 65535));
            ll = 1'($urandom_range(0, 1));
            check("ready_held_pending", int'(lr), 0);
            tick();
        end
        lv = 1'b0;
        ll = 1'b0;
        swap_main();
        rd_rand(16);

        // symmetric bank: N=7, S=4
        for (int i = 0; i < 4; i++) begin
            s_lv = 1'b1;
            s_ld = 16'((i + 1) * 10);
            s_ll = (i == 3);
            tick();
        end
        s_lv = 1'b0;
        s_ll = 1'b0;
        check("sym_pending", int'(s_sp), 1);
        s_sa = 1'b1;
        tick();
        s_sa = 1'b0;
        for (int i = 0; i < 4; i++) m_sym[i] = (i + 1) * 10;
        check("sym_bank_sel", int'(s_bs), 1);
        for (int c = 0; c < 8; c++) rd_sym(c);

        // reset while pending, with bank 1 active
        fill_rand();
        load_main(64, 63, 1'b0);
        check("bank1_before_rst", int'(bs), 1);
        check("pending_before_rst", int'(sp), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) m_active[i] = 0;
        for (int i = 0; i < 4; i++) m_sym[i] = 0;
        m_bank = 0;
        check("bank_sel_rst2", int'(bs), 0);
        check("pending_rst2", int'(sp), 0);
        check("error_rst2", int'(le), 0);
        check("coeff_rst2", int'(cf), 0);
        check("ready_rst2", int'(lr), 1);
        rd_rand(16);
        rd_sym(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
